stopwatch_counter: RTL and testbench
====================================

// Module: stopwatch_counter
// PURPOSE
//   Time-keeping core of the stopwatch: holds minutes:seconds as four BCD digits.
//   Sits downstream of clk_divider and the debouncers, and upstream of the display mux.
//   Two modes:
//     - Run: counts one second per 1 Hz tick.
//     - Adjust: advances the field chosen by sel at 2 Hz.
//   A debounced pause pulse toggles the run/paused state.
// PARAMETERS
//   MIN_MAX     59  highest minute value; range 1..99; minutes wrap MIN_MAX -> 00
//   START_PAUSED 0  run state after reset (0 = running, 1 = paused)
// PORTS
//   clk          in   1  system clock; the only clock
//   rst          in   1  synchronous reset, active-high
//   tick_1hz     in   1  one-clk-wide enable pulse at 1 Hz, from clk_divider
//   tick_2hz     in   1  one-clk-wide enable pulse at 2 Hz, from clk_divider
//   pause_pulse  in   1  one-clk-wide pulse per debounced pause press
//   adj          in   1  level; 1 = adjust mode
//   sel          in   1  level; adjust target: 0 = minutes, 1 = seconds
//   min_tens     out  4  BCD minutes tens digit
//   min_ones     out  4  BCD minutes ones digit
//   sec_tens     out  4  BCD seconds tens digit (0..5)
//   sec_ones     out  4  BCD seconds ones digit
//   paused       out  1  1 while run-mode counting is halted by pause
// BEHAVIOUR
//   - All state is updated on posedge clk only. Every output is a register.
//   - A qualifying tick sampled at edge N is visible on the outputs after edge N.
//   - Reset (rst = 1 at an edge):
//       digits <= 0;  paused <= START_PAUSED.
//       rst overrides every other input in that cycle and may be asserted mid-count.
//   - Pause:
//       pause_pulse = 1 toggles paused.
//       The toggle is honoured in both run and adjust mode.
//   - Run mode (adj = 0, paused = 0):
//       tick_1hz increments seconds; tick_2hz is ignored.
//       sec_ones 9 -> 0 carries into sec_tens; 59 s -> 00 s carries +1 into minutes.
//       Minutes count in BCD; MIN_MAX -> 00 wraps, so MIN_MAX:59 -> 00:00.
//   - Run mode (adj = 0, paused = 1): digits are held.
//   - Adjust mode (adj = 1): tick_1hz is ignored; counting stops whatever paused is.
//     On each tick_2hz:
//       sel = 1: seconds +1, wrapping 59 -> 00 with NO carry into minutes.
//       sel = 0: minutes +1, wrapping MIN_MAX -> 00; seconds are unchanged.
//     adj 1 -> 0: run mode resumes from the adjusted value under the current paused state.
//   - Simultaneous events in one cycle:
//       - The tick is qualified by the paused value registered before that edge.
//       - The pause toggle applies at the same edge.
//       - Example: pause_pulse and tick_1hz together while running -> the second
//         increments AND paused becomes 1.
//       - tick_1hz and tick_2hz together: only the one valid for the current mode acts.
//       - sel or adj changing in the same cycle as a tick: the values sampled at
//         that edge decide the action.
//   - Invariants:
//       - Every digit is always valid BCD (0..9); sec_tens is 0..5.
//       - Minutes never exceed MIN_MAX.
//       - Each qualifying tick produces exactly one increment.
// TESTING
//   1. rst = 1 for 1 cycle from 07:33, paused = 1 -> 00:00, paused = START_PAUSED on the next cycle.
//   2. Run mode from 00:58, three tick_1hz -> 00:59, 01:00, 01:01; tick_2hz pulses cause no change.
//   3. MIN_MAX = 59 at 59:59, one tick_1hz -> 00:00; with MIN_MAX = 99 at 99:59 -> 00:00.
//   4. adj = 1, sel = 1 at 12:58, three tick_2hz -> 12:59, 12:00, 12:01 (no minute carry);
//      sel = 0 at 59:xx, one tick_2hz -> 00:xx.
//   5. pause_pulse then 5 tick_1hz -> time unchanged and paused = 1;
//      second pause_pulse then 1 tick_1hz -> +1 s, paused = 0.
//   6. pause_pulse and tick_1hz in the same cycle while running at 00:10
//      -> 00:11 and paused = 1; the next tick_1hz leaves 00:11.

Source files
------------

// File: rtl/stopwatch_counter.sv
// Stopwatch time-keeping core: minutes:seconds held as four BCD digit registers.
// Run mode counts on tick_1hz_i; adjust mode bumps the selected field on tick_2hz_i.
module stopwatch_counter #(
  parameter int unsigned MIN_MAX      = 59,
  parameter bit          START_PAUSED = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_1hz_i,
  input  logic       tick_2hz_i,
  input  logic       pause_pulse_i,
  input  logic       adj_i,
  input  logic       sel_i,
  output logic [3:0] min_tens_o,
  output logic [3:0] min_ones_o,
  output logic [3:0] sec_tens_o,
  output logic [3:0] sec_ones_o,
  output logic       paused_o
);

  localparam logic [3:0] MAX_T = 4'(MIN_MAX / 10);
  localparam logic [3:0] MAX_O = 4'(MIN_MAX % 10);

  logic [3:0] min_t_q, min_o_q, sec_t_q, sec_o_q;
  logic [3:0] min_t_d, min_o_d, sec_t_d, sec_o_d;
  logic       paused_q, paused_d;

  logic run_tick, adj_sec, adj_min, sec_at_max, min_at_max;

  // Ticks are qualified by the paused value registered before this edge.
  assign run_tick   = !adj_i && !paused_q && tick_1hz_i;
  assign adj_sec    = adj_i && tick_2hz_i && sel_i;
  assign adj_min    = adj_i && tick_2hz_i && !sel_i;
  assign sec_at_max = (sec_t_q == 4'd5) && (sec_o_q == 4'd9);
  assign min_at_max = (min_t_q == MAX_T) && (min_o_q == MAX_O);

  always_comb begin
    sec_t_d  = sec_t_q;
    sec_o_d  = sec_o_q;
    min_t_d  = min_t_q;
    min_o_d  = min_o_q;
    paused_d = paused_q ^ pause_pulse_i;

    if (run_tick || adj_sec) begin
      if (sec_o_q == 4'd9) begin
        sec_o_d = 4'd0;
        sec_t_d = (sec_t_q == 4'd5) ? 4'd0 : sec_t_q + 4'd1;
      end else begin
        sec_o_d = sec_o_q + 4'd1;
      end
    end

    // Adjusting seconds never carries; only a run-mode rollover does.
    if (adj_min || (run_tick && sec_at_max)) begin
      if (min_at_max) begin
        min_t_d = 4'd0;
        min_o_d = 4'd0;
      end else if (min_o_q == 4'd9) begin
        min_o_d = 4'd0;
        min_t_d = min_t_q + 4'd1;
      end else begin
        min_o_d = min_o_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      min_t_q  <= 4'd0;
      min_o_q  <= 4'd0;
      sec_t_q  <= 4'd0;
      sec_o_q  <= 4'd0;
      paused_q <= START_PAUSED;
    end else begin
      min_t_q  <= min_t_d;
      min_o_q  <= min_o_d;
      sec_t_q  <= sec_t_d;
      sec_o_q  <= sec_o_d;
      paused_q <= paused_d;
    end
  end

  assign min_tens_o = min_t_q;
  assign min_ones_o = min_o_q;
  assign sec_tens_o = sec_t_q;
  assign sec_ones_o = sec_o_q;
  assign paused_o   = paused_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: two instances (MIN_MAX 59 and 99) against a
// time-in-integers reference model, plus a vector table and directed corner sequences.
module tb_stopwatch_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, t1, t2, pp, adj, sel;
  logic [3:0] a_mt, a_mo, a_st, a_so, b_mt, b_mo, b_st, b_so;
  logic       a_p, b_p;

  stopwatch_counter #(.MIN_MAX(59), .START_PAUSED(1'b0)) dut59 (
    .clk_i(clk), .rst_i(rst), .tick_1hz_i(t1), .tick_2hz_i(t2),
    .pause_pulse_i(pp), .adj_i(adj), .sel_i(sel),
    .min_tens_o(a_mt), .min_ones_o(a_mo), .sec_tens_o(a_st), .sec_ones_o(a_so),
    .paused_o(a_p));

  stopwatch_counter #(.MIN_MAX(99), .START_PAUSED(1'b0)) dut99 (
    .clk_i(clk), .rst_i(rst), .tick_1hz_i(t1), .tick_2hz_i(t2),
    .pause_pulse_i(pp), .adj_i(adj), .sel_i(sel),
    .min_tens_o(b_mt), .min_ones_o(b_mo), .sec_tens_o(b_st), .sec_ones_o(b_so),
    .paused_o(b_p));

  int vectors = 0;
  int miscompares = 0;

  // Reference model: plain integer minutes and seconds per instance.
  int m_sec;
  int m_min [2];
  bit m_paused;
  int mx [2] = '{59, 99};

  typedef struct {
    bit r, a, b, c, d, e;
    int emin, esec;
    bit ep;
  } vec_t;
  vec_t tbl [20];

  function automatic vec_t mk(bit r, bit a, bit b, bit c, bit d, bit e,
                              int emin, int esec, bit ep);
    vec_t v;
    v.r = r; v.a = a; v.b = b; v.c = c; v.d = d; v.e = e;
    v.emin = emin; v.esec = esec; v.ep = ep;
    return v;
  endfunction

  function automatic logic [16:0] pack(int mi, int se, bit p);
    return {4'(mi / 10), 4'(mi % 10), 4'(se / 10), 4'(se % 10), p};
  endfunction

  task automatic model_step();
    if (rst) begin
      m_sec = 0; m_min[0] = 0; m_min[1] = 0; m_paused = 1'b0;
    end else begin
      if (adj) begin
        if (t2 && sel) m_sec = (m_sec + 1) % 60;
        else if (t2) for (int k = 0; k < 2; k++)
          m_min[k] = (m_min[k] == mx[k]) ? 0 : m_min[k] + 1;
      end else if (!m_paused && t1) begin
        m_sec = m_sec + 1;
        if (m_sec == 60) begin
          m_sec = 0;
          for (int k = 0; k < 2; k++)
            m_min[k] = (m_min[k] == mx[k]) ? 0 : m_min[k] + 1;
        end
      end
      if (pp) m_paused = !m_paused;
    end
  endtask

  task automatic check_one(string name, logic [16:0] act, logic [16:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h%h:%h%h p=%b, want %h%h:%h%h p=%b", name,
               act[16:13], act[12:9], act[8:5], act[4:1], act[0],
               exp[16:13], exp[12:9], exp[8:5], exp[4:1], exp[0]);
    end
  endtask

  task automatic step(bit r, bit a, bit b, bit c, bit d, bit e);
    @(negedge clk);
    rst = r; t1 = a; t2 = b; pp = c; adj = d; sel = e;
    @(posedge clk);
    model_step();
    #1;
    check_one("model59", {a_mt, a_mo, a_st, a_so, a_p}, pack(m_min[0], m_sec, m_paused));
    check_one("model99", {b_mt, b_mo, b_st, b_so, b_p}, pack(m_min[1], m_sec, m_paused));
  endtask

  task automatic expect59(string name, int mi, int se, bit p);
    check_one(name, {a_mt, a_mo, a_st, a_so, a_p}, pack(mi, se, p));
  endtask

  task automatic expect99(string name, int mi, int se, bit p);
    check_one(name, {b_mt, b_mo, b_st, b_so, b_p}, pack(mi, se, p));
  endtask

  task automatic set_time(int mins, int secs);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < mins; i++) step(0, 0, 1, 0, 1, 0);
    for (int i = 0; i < secs; i++) step(0, 0, 1, 0, 1, 1);
  endtask

  initial begin
    rst = 1'b1; t1 = 0; t2 = 0; pp = 0; adj = 0; sel = 0;
    //               r t1 t2 pp adj sel  min sec p
    tbl[0]  = mk(0, 1, 0, 0, 0, 0,   0, 59, 0);
    tbl[1]  = mk(0, 0, 1, 0, 0, 0,   0, 59, 0);
    tbl[2]  = mk(0, 1, 0, 0, 0, 0,   1,  0, 0);
    tbl[3]  = mk(0, 1, 1, 0, 0, 0,   1,  1, 0);
    tbl[4]  = mk(0, 1, 0, 0, 1, 1,   1,  1, 0);
    tbl[5]  = mk(0, 0, 0, 1, 0, 0,   1,  1, 1);
    tbl[6]  = mk(0, 1, 0, 0, 0, 0,   1,  1, 1);
    tbl[7]  = mk(0, 1, 0, 0, 0, 0,   1,  1, 1);
    tbl[8]  = mk(0, 1, 0, 1, 0, 0,   1,  1, 0);
    tbl[9]  = mk(0, 1, 0, 0, 0, 0,   1,  2, 0);
    tbl[10] = mk(0, 0, 1, 0, 1, 0,   2,  2, 0);
    tbl[11] = mk(0, 0, 1, 0, 1, 1,   2,  3, 0);
    tbl[12] = mk(0, 0, 1, 1, 1, 1,   2,  4, 1);
    tbl[13] = mk(0, 0, 1, 0, 1, 0,   3,  4, 1);
    tbl[14] = mk(0, 1, 0, 0, 0, 0,   3,  4, 1);
    tbl[15] = mk(0, 0, 0, 1, 0, 0,   3,  4, 0);
    tbl[16] = mk(0, 1, 0, 1, 0, 0,   3,  5, 1);
    tbl[17] = mk(0, 1, 0, 0, 0, 0,   3,  5, 1);
    tbl[18] = mk(1, 1, 0, 1, 0, 0,   0,  0, 0);
    tbl[19] = mk(0, 1, 0, 0, 0, 0,   0,  1, 0);

    // Table run from 00:58, running.
    set_time(0, 58);
    expect59("start_00_58", 0, 58, 0);
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].e);
      expect59($sformatf("tbl[%0d]", i), tbl[i].emin, tbl[i].esec, tbl[i].ep);
    end

    // Reset from 07:33 while paused.
    set_time(7, 33);
    step(0, 0, 0, 1, 0, 0);
    expect59("pre_rst_07_33", 7, 33, 1);
    step(1, 0, 0, 0, 0, 0);
    expect59("rst_clears", 0, 0, 0);
    expect99("rst_clears99", 0, 0, 0);

    // Pause + tick together at 00:10.
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    expect59("pp_tick_same", 0, 11, 1);
    step(0, 1, 0, 0, 0, 0);
    expect59("paused_hold", 0, 11, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0);
    expect59("paused_5ticks", 0, 11, 1);
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    expect59("unpause_tick", 0, 12, 0);

    // Seconds adjust wraps with no minute carry; minute adjust wraps at MIN_MAX.
    set_time(12, 58);
    step(0, 0, 1, 0, 1, 1); expect59("adj_sec_59", 12, 59, 0);
    step(0, 0, 1, 0, 1, 1); expect59("adj_sec_wrap", 12, 0, 0);
    step(0, 0, 1, 0, 1, 1); expect59("adj_sec_01", 12, 1, 0);
    for (int i = 0; i < 47; i++) step(0, 0, 1, 0, 1, 0);
    expect59("adj_min_59", 59, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    expect59("adj_min_wrap", 0, 1, 0);
    expect99("adj_min_60", 60, 1, 0);

    // Full rollover at MIN_MAX:59 for both instances.
    set_time(59, 59);
    step(0, 1, 0, 0, 0, 0);
    expect59("roll_59_59", 0, 0, 0);
    expect99("roll99_60_00", 60, 0, 0);
    set_time(99, 59);
    expect99("pre_99_59", 99, 59, 0);
    step(0, 1, 0, 0, 0, 0);
    expect99("roll_99_59", 0, 0, 0);
    expect59("mod_39_59", 40, 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) == 0), 1'($urandom));
    end
    step(0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
